// File: rtl/v30mz_pkg.sv
// Shared v30mz bus definitions: status codes, responder FSM states and the data value
// returned for cycles that have no memory behind them.
package v30mz_pkg;

    localparam logic [3:0]  BUS_IDLE          = 4'hF;
    localparam logic [3:0]  BUS_FETCH         = 4'h9;
    localparam logic [3:0]  BUS_MRD           = 4'hA;
    localparam logic [3:0]  BUS_MWR           = 4'hB;
    localparam logic [15:0] BUS_UNMAPPED_DATA = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4,
        ST_RECOVER = 3'd5
    } resp_state_e;

    function automatic logic is_mem_read(input logic [3:0] status);
        return (status == BUS_FETCH) || (status == BUS_MRD);
    endfunction

endpackage

// File: rtl/v30mz_bus_responder.sv
// Target end of the v30mz external bus: runs one memory cycle per accepted request,
// with programmable wait states and a single-cycle active-low readyb response.
module v30mz_bus_responder
    import v30mz_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int MEM_AW      = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        bus_status,
    input  logic [19:0]       address_in,
    input  logic [15:0]       wdata_in,
    input  logic              ubeb,
    output logic              readyb,
    output logic [15:0]       rdata_out,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic [2:0]        state
);

    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    resp_state_e       r_state;
    resp_state_e       w_state_next;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_wait_cnt_next;
    logic [3:0]        r_status;
    logic              r_readyb;
    logic [15:0]       r_rdata;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [1:0]        r_mem_be;
    logic [15:0]       r_mem_wdata;

    logic              w_accept;
    logic              w_enter_access;
    logic [3:0]        w_cmd_status;

    assign w_accept       = (r_state == ST_IDLE) && (bus_status != BUS_IDLE);
    // With zero wait states the strobe is decided on the accepting edge, before r_status exists.
    assign w_cmd_status   = (r_state == ST_IDLE) ? bus_status : r_status;
    assign w_enter_access = (w_state_next == ST_ACCESS);

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus_status != BUS_IDLE) begin
                    if (WAIT_STATES == 0) begin
                        w_state_next = ST_ACCESS;
                    end else begin
                        w_state_next    = ST_WAIT;
                        w_wait_cnt_next = WAIT_INIT;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Core withdrawing its request before the access aborts with no side effects.
                if (bus_status == BUS_IDLE) begin
                    w_state_next    = ST_IDLE;
                    w_wait_cnt_next = 4'd0;
                end else if (r_wait_cnt == 4'd0) begin
                    w_state_next = ST_ACCESS;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                end
            end
            ST_ACCESS:  w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = ST_RESP;
            ST_RESP:    w_state_next = ST_RECOVER;
            ST_RECOVER: begin
                if (bus_status == BUS_IDLE) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RECOVER;
                end
            end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // State, request latches, memory strobes and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 4'd0;
            r_status    <= BUS_IDLE;
            r_readyb    <= 1'b1;
            r_rdata     <= BUS_UNMAPPED_DATA;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_be    <= 2'b00;
            r_mem_wdata <= 16'h0000;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_accept) begin
                r_status    <= bus_status;
                r_mem_addr  <= address_in[MEM_AW:1];
                r_mem_wdata <= wdata_in;
                r_mem_be    <= (bus_status == BUS_MWR) ? {~ubeb, ~address_in[0]} : 2'b11;
            end
            r_mem_rd <= w_enter_access && is_mem_read(w_cmd_status);
            r_mem_wr <= w_enter_access && (w_cmd_status == BUS_MWR);
            r_readyb <= (r_state != ST_CAPTURE);
            // Writes leave the last read data on rdata_out untouched.
            if (r_state == ST_CAPTURE) begin
                if (is_mem_read(r_status)) begin
                    r_rdata <= mem_rdata;
                end else if (r_status != BUS_MWR) begin
                    r_rdata <= BUS_UNMAPPED_DATA;
                end
            end
        end
    end

    assign readyb    = r_readyb;
    assign rdata_out = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign state     = r_state;

endmodule

// File: tb/tb_v30mz_bus_responder.sv
// Bench for v30mz_bus_responder: three instances (0, 3 and 4 wait states), each with its own
// registered word memory, checked against a transaction-level timing and memory reference.
module tb_v30mz_bus_responder;
    import v30mz_pkg::*;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst_n  [NDUT];
    logic [3:0]  bs     [NDUT];
    logic [19:0] addr   [NDUT];
    logic [15:0] wd     [NDUT];
    logic        ub     [NDUT];
    logic        rdy    [NDUT];
    logic [15:0] rdata  [NDUT];
    logic [18:0] maddr  [NDUT];
    logic        mrd    [NDUT];
    logic        mwr    [NDUT];
    logic [1:0]  mbe    [NDUT];
    logic [15:0] mwd    [NDUT];
    logic [15:0] mrdata [NDUT];
    logic [2:0]  st     [NDUT];

    logic [15:0] tmem  [NDUT][1024];
    bit          twr   [NDUT][1024];
    logic [15:0] rmem  [NDUT][1024];
    bit          rval  [NDUT][1024];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    v30mz_bus_responder #(.WAIT_STATES(0), .MEM_AW(19)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .bus_status(bs[0]), .address_in(addr[0]),
        .wdata_in(wd[0]), .ubeb(ub[0]), .readyb(rdy[0]), .rdata_out(rdata[0]),
        .mem_addr(maddr[0]), .mem_rd(mrd[0]), .mem_wr(mwr[0]), .mem_be(mbe[0]),
        .mem_wdata(mwd[0]), .mem_rdata(mrdata[0]), .state(st[0]));

    v30mz_bus_responder #(.WAIT_STATES(3), .MEM_AW(19)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .bus_status(bs[1]), .address_in(addr[1]),
        .wdata_in(wd[1]), .ubeb(ub[1]), .readyb(rdy[1]), .rdata_out(rdata[1]),
        .mem_addr(maddr[1]), .mem_rd(mrd[1]), .mem_wr(mwr[1]), .mem_be(mbe[1]),
        .mem_wdata(mwd[1]), .mem_rdata(mrdata[1]), .state(st[1]));

    v30mz_bus_responder #(.WAIT_STATES(4), .MEM_AW(19)) u_dut2 (
        .clk(clk), .reset(rst_n[2]), .bus_status(bs[2]), .address_in(addr[2]),
        .wdata_in(wd[2]), .ubeb(ub[2]), .readyb(rdy[2]), .rdata_out(rdata[2]),
        .mem_addr(maddr[2]), .mem_rd(mrd[2]), .mem_wr(mwr[2]), .mem_be(mbe[2]),
        .mem_wdata(mwd[2]), .mem_rdata(mrdata[2]), .state(st[2]));

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [15:0] init_word(input logic [9:0] wa);
        logic [15:0] v;
        v = ({6'd0, wa} * 16'd40503) ^ 16'h3C5A;
        if (wa == 10'h3F8) v = 16'hEA12;
        return v;
    endfunction

    function automatic logic [15:0] merge_bytes(input logic [15:0] old, input logic [15:0] data,
                                                input logic [1:0] be);
        logic [15:0] w;
        w = old;
        if (be[1]) w[15:8] = data[15:8];
        if (be[0]) w[7:0]  = data[7:0];
        return w;
    endfunction

    function automatic logic [15:0] mem_word(input int d, input logic [9:0] wa);
        return twr[d][wa] ? tmem[d][wa] : init_word(wa);
    endfunction

    function automatic logic [15:0] ref_read(input int d, input logic [9:0] wa);
        return rval[d][wa] ? rmem[d][wa] : init_word(wa);
    endfunction

    function automatic void ref_write(input int d, input logic [9:0] wa, input logic [1:0] be,
                                      input logic [15:0] data);
        rmem[d][wa] = merge_bytes(ref_read(d, wa), data, be);
        rval[d][wa] = 1'b1;
    endfunction

    // Registered single-port memories, one per instance: read data appears the cycle after mem_rd.
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (mrd[d]) mrdata[d] <= mem_word(d, maddr[d][9:0]);
            if (mwr[d]) begin
                tmem[d][maddr[d][9:0]] <= merge_bytes(mem_word(d, maddr[d][9:0]), mwd[d], mbe[d]);
                twr[d][maddr[d][9:0]]  <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk({tag, ".readyb"}, 32'(rdy[d]), 32'd1);
        chk({tag, ".rdata"},  32'(rdata[d]), 32'hFFFF);
        chk({tag, ".mem_rd"}, 32'(mrd[d]), 32'd0);
        chk({tag, ".mem_wr"}, 32'(mwr[d]), 32'd0);
        chk({tag, ".mem_addr"}, 32'(maddr[d]), 32'd0);
        chk({tag, ".mem_be"}, 32'(mbe[d]), 32'd0);
        chk({tag, ".mem_wdata"}, 32'(mwd[d]), 32'd0);
        chk({tag, ".state"}, 32'(st[d]), 32'(ST_IDLE));
    endtask

    // One bus cycle: strobe expected WS cycles after the accept edge, readyb WS+2 cycles after.
    task automatic run_txn(input int d, input logic [3:0] s, input logic [19:0] a,
                           input logic [15:0] data, input logic u, input int hold,
                           input int abort_at, input string tag);
        int ws; int len; int n_strobe; int strobe_at; int n_rdy; int rdy_at;
        bit is_rd; bit is_wr;
        logic [15:0] exp_data;
        logic [1:0]  exp_be;
        ws        = ws_of(d);
        is_rd     = (s == BUS_FETCH) || (s == BUS_MRD);
        is_wr     = (s == BUS_MWR);
        exp_data  = is_rd ? ref_read(d, a[10:1]) : 16'hFFFF;
        exp_be    = is_wr ? {~u, ~a[0]} : 2'b11;
        len       = ws + 8 + hold;
        n_strobe  = 0; strobe_at = -1; n_rdy = 0; rdy_at = -1;
        @(negedge clk);
        bs[d] = s; addr[d] = a; wd[d] = data; ub[d] = u;
        @(posedge clk);
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            if (n == 0) begin
                addr[d] = 20'($urandom); wd[d] = 16'($urandom); ub[d] = ~u;
            end
            if (mrd[d] || mwr[d]) begin
                n_strobe++; strobe_at = n;
                chk({tag, ".mem_rd"}, 32'(mrd[d]), 32'(is_rd));
                chk({tag, ".mem_wr"}, 32'(mwr[d]), 32'(is_wr));
                chk({tag, ".mem_addr"}, 32'(maddr[d]), 32'(a[19:1]));
                chk({tag, ".mem_be"}, 32'(mbe[d]), 32'(exp_be));
                if (is_wr) chk({tag, ".mem_wdata"}, 32'(mwd[d]), 32'(data));
            end
            if (rdy[d] == 1'b0) begin
                n_rdy++; rdy_at = n;
                if (!is_wr) chk({tag, ".rdata"}, 32'(rdata[d]), 32'(exp_data));
            end
            if (n == abort_at) bs[d] = BUS_IDLE;
            if (rdy_at >= 0 && n == rdy_at + hold) bs[d] = BUS_IDLE;
        end
        if (abort_at >= 0) begin
            chk({tag, ".abort_strobes"}, 32'(n_strobe), 32'd0);
            chk({tag, ".abort_ready"}, 32'(n_rdy), 32'd0);
        end else begin
            chk({tag, ".strobes"}, 32'(n_strobe), (is_rd || is_wr) ? 32'd1 : 32'd0);
            if (is_rd || is_wr) chk({tag, ".strobe_at"}, 32'(strobe_at), 32'(ws));
            chk({tag, ".ready_cnt"}, 32'(n_rdy), 32'd1);
            chk({tag, ".ready_at"}, 32'(rdy_at), 32'(ws + 2));
            if (!is_wr) chk({tag, ".rdata_held"}, 32'(rdata[d]), 32'(exp_data));
            if (is_wr) ref_write(d, a[10:1], exp_be, data);
        end
        chk({tag, ".end_state"}, 32'(st[d]), 32'(ST_IDLE));
        chk({tag, ".end_readyb"}, 32'(rdy[d]), 32'd1);
    endtask

    initial begin
        int d; int pick; int hold; int abort_at;
        logic [3:0] s;
        logic [19:0] a;
        for (int i = 0; i < NDUT; i++) begin
            rst_n[i] = 1'b1; bs[i] = BUS_IDLE; addr[i] = 20'h0; wd[i] = 16'h0; ub[i] = 1'b1;
        end
        #1;
        for (int i = 0; i < NDUT; i++) rst_n[i] = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) chk_reset(i, $sformatf("reset%0d", i));
        repeat (2) @(negedge clk);
        for (int i = 0; i < NDUT; i++) rst_n[i] = 1'b1;

        run_txn(0, BUS_FETCH, 20'hFFFF0, 16'h0000, 1'b1, 0, -1, "fetch_ws0");
        run_txn(1, BUS_FETCH, 20'hFFFF0, 16'h0000, 1'b1, 0, -1, "fetch_ws3");
        run_txn(0, BUS_MWR,   20'h00101, 16'h55AA, 1'b0, 0, -1, "write_hi");
        run_txn(0, BUS_MRD,   20'h00100, 16'h0000, 1'b1, 0, -1, "readback");
        run_txn(0, BUS_FETCH, 20'hFFFF0, 16'h0000, 1'b1, 3, -1, "held_fetch");
        run_txn(2, BUS_FETCH, 20'hFFFF0, 16'h0000, 1'b1, 0, 1, "abort_ws4");

        // Reset asserted while a write sits in its access cycle.
        @(negedge clk);
        bs[0] = BUS_MWR; addr[0] = 20'h00202; wd[0] = 16'hBEEF; ub[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wr.access_strobe", 32'(mwr[0]), 32'd1);
        rst_n[0] = 1'b0;
        #1;
        chk_reset(0, "rst_wr");
        bs[0] = BUS_IDLE;
        @(negedge clk);
        rst_n[0] = 1'b1;
        run_txn(0, BUS_MRD, 20'h00202, 16'h0000, 1'b1, 0, -1, "rst_wr_readback");

        run_txn(0, 4'h8, 20'h00100, 16'h0000, 1'b1, 0, -1, "unsup_ws0");
        run_txn(1, 4'hC, 20'h00100, 16'h0000, 1'b1, 0, -1, "unsup_ws3");

        for (int i = 0; i < 45; i++) begin
            d    = $urandom_range(0, 2);
            pick = $urandom_range(0, 9);
            s    = (pick < 3) ? BUS_FETCH : (pick < 5) ? BUS_MRD : (pick < 9) ? BUS_MWR : 4'h8;
            a    = {9'($urandom), 10'($urandom_range(0, 15)), 1'($urandom)};
            hold = $urandom_range(0, 2);
            abort_at = -1;
            if (ws_of(d) > 0 && $urandom_range(0, 4) == 0) abort_at = $urandom_range(0, ws_of(d) - 1);
            run_txn(d, s, a, 16'($urandom), 1'($urandom), hold, abort_at,
                    $sformatf("rand%0d_d%0d", i, d));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
